apb_reg_bank: RTL and testbench

APB_REG_BANK -- requirements
Module: apb_reg_bank

---
 rtl/apb_reg_pkg.sv | 15 +
 rtl/apb_reg_cell.sv | 41 ++++
 rtl/apb_reg_bank.sv | 136 +++++++++++++
 tb/tb_apb_reg_bank.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_pkg.sv
// Shared encodings for the APB register bank: per-register access modes and
// the transfer FSM state type.
package apb_reg_pkg;

    localparam logic [1:0] MODE_RW    = 2'd0;
    localparam logic [1:0] MODE_RO    = 2'd1;
    localparam logic [1:0] MODE_W1C   = 2'd2;
    localparam logic [1:0] MODE_PULSE = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/apb_reg_cell.sv
// One register of the bank; its write/hold behaviour is fixed at elaboration
// by MODE (RW, RO, W1C or PULSE).
module apb_reg_cell
    import apb_reg_pkg::*;
#(
    parameter logic [1:0]        MODE      = MODE_RW,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] hw_set,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        case (MODE)
            MODE_RW:  if (we) q_d = wdata;
            MODE_RO:  q_d = '0;
            // Hardware set is OR-ed in last so it wins over a same-cycle clear.
            MODE_W1C: q_d = (q_q & ~(we ? wdata : '0)) | hw_set;
            default:  q_d = we ? wdata : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= (MODE == MODE_RW || MODE == MODE_W1C) ? RESET_VAL : '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/apb_reg_bank.sv
// APB3 slave register bank: setup/access FSM with optional wait states,
// address decode with error response, registered read data and W1C interrupt.
module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int unsigned                 NUM_REGS    = 8,
    parameter int unsigned                 DATA_W      = 32,
    parameter int unsigned                 WAIT_STATES = 0,
    parameter logic [2*NUM_REGS-1:0]       REG_MODE    = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [15:0]                  paddr,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [31:0]                  pwdata,
    output logic [31:0]                  prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_ro_d,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    output logic                         irq
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;

    logic              setup, load_rd, commit;
    logic [15:0]       rd_addr;
    logic [31:0]       prdata_d;
    logic [DATA_W-1:0] rd_val [NUM_REGS];
    logic [NUM_REGS-1:0] we;

    function automatic logic addr_err(input logic [15:0] a);
        return (a[1:0] != 2'b00) || (a[15:8] != 8'h00) || ({1'b0, a[7:2]} >= 7'(NUM_REGS));
    endfunction

    assign setup   = (state_q == ST_IDLE) && psel && !penable;
    assign pready  = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign pslverr = pready && addr_err(addr_q);
    assign commit  = pready && write_q && !addr_err(addr_q);

    // prdata loads on the edge that leads into the pready cycle.
    assign load_rd = (setup && (WAIT_STATES == 0))
                   || ((state_q == ST_ACCESS) && psel && (cnt_q == 4'd1));
    assign rd_addr = setup ? paddr : addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ST_ACCESS: begin
                if (pready) begin
                    state_d = ST_IDLE;
                end else if (!psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prdata_d = '0;
        if (!addr_err(rd_addr)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr[7:2] == 6'(i)) prdata_d[DATA_W-1:0] = rd_val[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            write_q <= 1'b0;
            wdata_q <= '0;
            prdata  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata[DATA_W-1:0];
            end
            if (load_rd) prdata <= prdata_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        localparam logic [1:0] MODE = REG_MODE[2*g +: 2];

        assign we[g] = commit && (addr_q[7:2] == 6'(g));

        apb_reg_cell #(
            .MODE      (MODE),
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL[g*DATA_W +: DATA_W])
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .we     (we[g]),
            .wdata  (wdata_q),
            .hw_set (hw_set[g*DATA_W +: DATA_W]),
            .q      (reg_q[g*DATA_W +: DATA_W])
        );

        assign rd_val[g] = (MODE == MODE_RO)    ? reg_ro_d[g*DATA_W +: DATA_W] :
                           (MODE == MODE_PULSE) ? '0 : reg_q[g*DATA_W +: DATA_W];
    end

    always_comb begin
        irq = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (REG_MODE[2*i +: 2] == MODE_W1C) irq = irq | (|reg_q[i*DATA_W +: DATA_W]);
        end
    end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench: three banks (0, 2 and 3 wait states) share one APB bus and are checked
// every cycle against a per-bank register model.
module tb_apb_reg_bank;

    localparam int NK = 3;
    localparam int NR = 8;
    localparam logic [15:0]  MODES = 16'h6390;
    localparam logic [255:0] RSTV  = {32'h0000_0000, 32'h0000_0000, 32'h0000_00C3, 32'hFFFF_FFFF,
                                      32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1111_0000};

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  paddr;
    logic         psel, penable, pwrite;
    logic [31:0]  pwdata;
    logic [255:0] reg_ro_d, hw_set;

    logic [31:0]  prdata  [NK];
    logic         pready  [NK];
    logic         pslverr [NK];
    logic         irq     [NK];
    logic [255:0] reg_q   [NK];

    logic [31:0]  m_reg [NK][NR];
    logic [31:0]  m_prd [NK];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        apb_reg_bank #(
            .NUM_REGS    (NR),
            .DATA_W      (32),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
            .REG_MODE    (MODES),
            .RESET_VAL   (RSTV)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .paddr    (paddr),
            .psel     (psel),
            .penable  (penable),
            .pwrite   (pwrite),
            .pwdata   (pwdata),
            .prdata   (prdata[g]),
            .pready   (pready[g]),
            .pslverr  (pslverr[g]),
            .reg_q    (reg_q[g]),
            .reg_ro_d (reg_ro_d),
            .hw_set   (hw_set),
            .irq      (irq[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    // 0 RW, 1 RO, 2 W1C, 3 PULSE
    function automatic int mode_of(input int i);
        case (i)
            2, 7:    return 1;
            3, 6:    return 2;
            4:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic bit is_err(input logic [15:0] a);
        return (a[1:0] != 2'b00) || (a[15:8] != 8'h00) || (int'(a[7:2]) >= NR);
    endfunction

    function automatic logic [31:0] read_val(input int k, input int i);
        if (mode_of(i) == 1) return reg_ro_d[i*32 +: 32];
        if (mode_of(i) == 3) return 32'h0;
        return m_reg[k][i];
    endfunction

    function automatic logic [255:0] exp_regq(input int k);
        logic [255:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = m_reg[k][i];
        return v;
    endfunction

    function automatic logic exp_irq(input int k);
        logic r = 1'b0;
        for (int i = 0; i < NR; i++) if (mode_of(i) == 2 && m_reg[k][i] != 32'h0) r = 1'b1;
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[k][i] = (mode_of(i) == 0 || mode_of(i) == 2) ? RSTV[i*32 +: 32] : 32'h0;
            end
            m_prd[k] = 32'h0;
        end
    endtask

    // One clock edge of register behaviour for bank k.
    task automatic model_edge(input int k, input bit commit, input int idx, input logic [31:0] d);
        for (int i = 0; i < NR; i++) begin
            bit hit = commit && (idx == i);
            case (mode_of(i))
                0:       if (hit) m_reg[k][i] = d;
                1:       m_reg[k][i] = 32'h0;
                2:       m_reg[k][i] = (m_reg[k][i] & ~(hit ? d : 32'h0)) | hw_set[i*32 +: 32];
                default: m_reg[k][i] = hit ? d : 32'h0;
            endcase
        end
    endtask

    // One APB transfer on the shared bus. drop_at/rst_at >= 0 drop psel or
    // pulse rst in the cycle after that sample; control fields are scrambled
    // once the access phase starts.
    task automatic xfer(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                        input int drop_at, input int rst_at,
                        input logic [255:0] hw_val, input logic [255:0] hw_mask);
        bit err;
        int idx;
        bit pr_ok [NK];
        bit cm_ok [NK];
        err = is_err(addr);
        idx = int'(addr[7:2]);
        for (int k = 0; k < NK; k++) begin
            pr_ok[k] = (drop_at < 0 || ws_of(k) <= drop_at) && (rst_at < 0 || ws_of(k) <= rst_at);
            cm_ok[k] = (drop_at < 0 || ws_of(k) <= drop_at) && (rst_at < 0 || ws_of(k) + 1 <= rst_at);
        end
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        psel    = 1'b1;
        penable = 1'b0;
        hw_set  = hw_val | (rand256() & hw_mask);
        for (int c = 0; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (rst_at >= 0 && c == rst_at + 1) begin
                model_reset();
            end else begin
                for (int k = 0; k < NK; k++) begin
                    if (pr_ok[k] && c == ws_of(k)) m_prd[k] = err ? 32'h0 : read_val(k, idx);
                    model_edge(k, cm_ok[k] && wr && !err && c == ws_of(k) + 1, idx, data);
                end
            end
            for (int k = 0; k < NK; k++) begin
                bit rdy = pr_ok[k] && (c == ws_of(k));
                check_eq($sformatf("pready[%0d] a=%h c=%0d", k, addr, c), 256'(pready[k]), 256'(rdy));
                check_eq($sformatf("pslverr[%0d] a=%h c=%0d", k, addr, c), 256'(pslverr[k]),
                         256'(rdy && err));
                check_eq($sformatf("prdata[%0d] a=%h c=%0d", k, addr, c), 256'(prdata[k]),
                         256'(m_prd[k]));
                check_eq($sformatf("reg_q[%0d] a=%h c=%0d", k, addr, c), reg_q[k], exp_regq(k));
                check_eq($sformatf("irq[%0d] a=%h c=%0d", k, addr, c), 256'(irq[k]),
                         256'(exp_irq(k)));
            end
            hw_set = hw_val | (rand256() & hw_mask);
            if (c == 0) begin
                penable = 1'b1;
                paddr   = 16'($urandom());
                pwrite  = 1'($urandom());
                pwdata  = $urandom();
            end
            if (c == drop_at || c == rst_at || c == 4) begin
                psel    = 1'b0;
                penable = 1'b0;
            end
            if (c == rst_at) rst = 1'b1;
            if (rst_at >= 0 && c == rst_at + 1) rst = 1'b0;
        end
    endtask

    initial begin
        logic [255:0] b3;
        b3       = 256'd1 << (3*32 + 3);
        rst      = 1'b1;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 16'h0;
        pwdata   = 32'h0;
        reg_ro_d = '0;
        hw_set   = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        for (int k = 0; k < NK; k++) begin
            check_eq($sformatf("rst pready[%0d]", k), 256'(pready[k]), 256'(0));
            check_eq($sformatf("rst pslverr[%0d]", k), 256'(pslverr[k]), 256'(0));
            check_eq($sformatf("rst prdata[%0d]", k), 256'(prdata[k]), 256'(0));
            check_eq($sformatf("rst irq[%0d]", k), 256'(irq[k]), 256'(0));
            check_eq($sformatf("rst reg_q[%0d]", k), reg_q[k], exp_regq(k));
        end
        rst = 1'b0;

        // RW write then read-back
        xfer(1'b1, 16'h0004, 32'hA5A5_1234, -1, -1, '0, '0);
        xfer(1'b0, 16'h0004, 32'h0, -1, -1, '0, '0);
        for (int k = 0; k < NK; k++)
            check_eq($sformatf("rw readback[%0d]", k), 256'(prdata[k]), 256'(32'hA5A5_1234));

        // RO read with hardware value
        reg_ro_d = 256'h0;
        reg_ro_d[2*32 +: 32] = 32'h0000_00FF;
        xfer(1'b0, 16'h0008, 32'h0, -1, -1, '0, '0);
        for (int k = 0; k < NK; k++)
            check_eq($sformatf("ro read[%0d]", k), 256'(prdata[k]), 256'(32'hFF));

        // W1C: set wins over a simultaneous clear, then clear alone
        xfer(1'b0, 16'h000C, 32'h0, -1, -1, b3, '0);
        for (int k = 0; k < NK; k++) check_eq($sformatf("w1c irq[%0d]", k), 256'(irq[k]), 256'(1));
        xfer(1'b1, 16'h000C, 32'h8, -1, -1, b3, '0);
        for (int k = 0; k < NK; k++)
            check_eq($sformatf("w1c held[%0d]", k), 256'(reg_q[k][3*32+3]), 256'(1));
        xfer(1'b1, 16'h000C, 32'h8, -1, -1, '0, '0);
        for (int k = 0; k < NK; k++) begin
            check_eq($sformatf("w1c clr[%0d]", k), 256'(reg_q[k][3*32+3]), 256'(0));
            check_eq($sformatf("w1c irq off[%0d]", k), 256'(irq[k]), 256'(0));
        end

        // PULSE write then read-back
        xfer(1'b1, 16'h0010, 32'h1, -1, -1, '0, '0);
        xfer(1'b0, 16'h0010, 32'h0, -1, -1, '0, '0);

        // Error responses: misaligned, out-of-range index, upper address bits
        xfer(1'b1, 16'h0002, 32'hFFFF_FFFF, -1, -1, '0, '0);
        xfer(1'b1, 16'h0020, 32'hFFFF_FFFF, -1, -1, '0, '0);
        xfer(1'b0, 16'h0020, 32'h0, -1, -1, '0, '0);
        xfer(1'b1, 16'h0104, 32'h5555_AAAA, -1, -1, '0, '0);

        // psel dropped mid-access, then reset mid-write
        xfer(1'b1, 16'h0014, 32'h7777_7777, 1, -1, '0, '0);
        xfer(1'b1, 16'h0004, 32'h0BAD_F00D, -1, 1, '0, '0);
        for (int k = 0; k < NK; k++)
            check_eq($sformatf("post-rst reg1[%0d]", k), 256'(reg_q[k][32 +: 32]),
                     256'(32'hDEAD_BEEF));
        xfer(1'b0, 16'h0004, 32'h0, -1, -1, '0, '0);
        for (int k = 0; k < NK; k++)
            check_eq($sformatf("post-rst read[%0d]", k), 256'(prdata[k]), 256'(32'hDEAD_BEEF));

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int sel;
            logic [15:0] a;
            int drop;
            sel = $urandom_range(0, 9);
            if (sel < 8) a = 16'(sel << 2);
            else if (sel == 8) a = 16'($urandom_range(8, 63) << 2);
            else a = 16'($urandom());
            drop = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
            reg_ro_d = rand256();
            xfer(1'($urandom()), a, $urandom(), drop, -1, '0, rand256() & rand256() & rand256());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
